sync_fifo_wc: RTL
=================

Name: sync_fifo_wc

Overview:
Parametrised single-clock FIFO with integer-ratio width conversion, STD/FWFT read modes, LSB/MSB packing order, programmable almost-full/almost-empty thresholds, synchronous flush and overflow/underflow pulses. It is the next generation of the team's sync_fifo and is used between datapath stages whose bus widths differ by a power of two.

Parameters:
INPUT_WIDTH, 32, write word width; ratio to OUTPUT_WIDTH is 1, 2, 4 or 8 (either direction)
OUTPUT_WIDTH, 8, read word width
WR_DEPTH, 16, capacity in input words, power of 2, >=4
RD_DEPTH, WR_DEPTH*INPUT_WIDTH/OUTPUT_WIDTH, capacity in output words (derived, localparam)
MODE, "FWFT", "FWFT" or "STD"
DIRECTION, "LSB", "LSB": first narrow word occupies/leaves bits [N-1:0]; "MSB": top slice first

Ports:
clock  in  1  sole clock, rising edge
reset_n  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear
wr_en  in  1  write request
din  in  INPUT_WIDTH  write data
rd_en  in  1  read request (STD) / pop acknowledge (FWFT)
valid  out  1  dout holds a valid word
dout  out  OUTPUT_WIDTH  read data
full  out  1  fewer than one input word of space
empty  out  1  no complete output word available
af_thresh  in  clog2(WR_DEPTH)+1  almost_full threshold, input words
ae_thresh  in  clog2(RD_DEPTH)+1  almost_empty threshold, output words
almost_full  out  1  wr_data_count >= af_thresh
almost_empty  out  1  rd_data_count <= ae_thresh
overflow  out  1  one-cycle pulse: write dropped
underflow  out  1  one-cycle pulse: read with no data
wr_data_count  out  clog2(WR_DEPTH)+1  stored data, whole input words (floor)
rd_data_count  out  clog2(RD_DEPTH)+1  stored data, whole output words, incl. FWFT head
wr_data_space  out  clog2(WR_DEPTH)+1  WR_DEPTH - wr_data_count
rd_data_space  out  clog2(RD_DEPTH)+1  RD_DEPTH - rd_data_count

Behaviour:
- Reset (reset_n low, async): pointers 0, valid=0, dout=0, full=0, empty=1, almost_empty=1, almost_full=(af_thresh==0), overflow=underflow=0, counts 0, spaces at maximum.
- Storage tracked in narrow units (min width); pointers one bit wider than the address for full/empty disambiguation; wrap modulo depth.
- Write: wr_en & !full stores din at edge; wr_en & full drops the write and pulses overflow next cycle. Full is evaluated before any same-cycle read: a write to a full FIFO is dropped even when rd_en pops.
- IW<OW: input words are packed into the current output word in DIRECTION order; word becomes readable (empty falls, rd_data_count increments) only once complete.
- IW>OW: each input word yields RATIO output words, slices emitted in DIRECTION order.
- STD: rd_en & !empty -> dout/valid registered next cycle (latency 1); valid is a one-cycle pulse per read. rd_en & empty -> no pop, underflow pulse.
- FWFT: head word prefetched to dout; valid rises 1 cycle after the edge that makes the first word available; rd_en & valid pops and presents the next word in the same cycle following the edge (continuous streaming at 1 word/clock). rd_en & !valid -> underflow pulse.
- Simultaneous read and write when not full/empty: both performed, counts net unchanged in equal-width case.
- Flags and counts are registered, consistent with the state after each edge.
- flush: at the edge, pointers, counts, valid and partial-pack state clear exactly as reset (dout holds its value); overrides same-cycle wr_en/rd_en; no overflow/underflow pulse.
- Threshold ports may change anytime; flags reflect the new value from the next edge.

Optional Feature:
SYNC_FIFO_PARITY_EN: when defined, an even-parity bit is stored per narrow unit, checked on read, and a port parity_err (out, 1) pulses with valid when any slice of dout mismatches; stored parity is forced via a bench-only force. When not defined: no parity storage, no parity_err port.

Test Plan:
- IW=32, OW=8, LSB, FWFT: write 32'h03020100 -> valid after 1 cycle, dout 00,01,02,03 with rd_en held; empty after 4th pop; rd_data_count 4->0.
- Same with DIRECTION="MSB": dout 03,02,01,00.
- IW=8, OW=32, STD: write 11,22,33 -> empty stays 1; 4th write 44 -> empty 0, rd_data_count=1; rd_en -> dout 32'h44332211 next cycle, valid pulse.
- IW=OW=16, WR_DEPTH=16: write 17 words with rd_en=0 -> full after 16th, overflow pulse on 17th, wr_data_count=16; rd_en on empty -> underflow pulse.
- af_thresh=12, ae_thresh=2: fill to 12 -> almost_full rises; drain to 2 -> almost_empty rises.
- Fill 10 words, assert flush with wr_en=rd_en=1 -> next cycle empty=1, counts 0, valid=0; reset_n pulse mid-stream -> immediate async return to reset values.

Source files
------------

// File: rtl/sync_fifo_wc_if.sv
// Bus bundle for sync_fifo_wc: write/read handshakes, thresholds, flags and occupancy counts.
// parity_err exists only when SYNC_FIFO_PARITY_EN is defined.
interface sync_fifo_wc_if #(
    parameter int INPUT_WIDTH  = 32,
    parameter int OUTPUT_WIDTH = 8,
    parameter int WR_DEPTH     = 16
);
    localparam int RD_DEPTH = WR_DEPTH * INPUT_WIDTH / OUTPUT_WIDTH;
    localparam int WCW      = $clog2(WR_DEPTH) + 1;
    localparam int RCW      = $clog2(RD_DEPTH) + 1;

    logic                    flush;
    logic                    wr_en;
    logic [INPUT_WIDTH-1:0]  din;
    logic                    rd_en;
    logic                    valid;
    logic [OUTPUT_WIDTH-1:0] dout;
    logic                    full;
    logic                    empty;
    logic [WCW-1:0]          af_thresh;
    logic [RCW-1:0]          ae_thresh;
    logic                    almost_full;
    logic                    almost_empty;
    logic                    overflow;
    logic                    underflow;
    logic [WCW-1:0]          wr_data_count;
    logic [RCW-1:0]          rd_data_count;
    logic [WCW-1:0]          wr_data_space;
    logic [RCW-1:0]          rd_data_space;
`ifdef SYNC_FIFO_PARITY_EN
    logic                    parity_err;
`endif

    modport master (
`ifdef SYNC_FIFO_PARITY_EN
        input  parity_err,
`endif
        output flush, wr_en, din, rd_en, af_thresh, ae_thresh,
        input  valid, dout, full, empty, almost_full, almost_empty, overflow, underflow,
        input  wr_data_count, rd_data_count, wr_data_space, rd_data_space
    );

    modport slave (
`ifdef SYNC_FIFO_PARITY_EN
        output parity_err,
`endif
        input  flush, wr_en, din, rd_en, af_thresh, ae_thresh,
        output valid, dout, full, empty, almost_full, almost_empty, overflow, underflow,
        output wr_data_count, rd_data_count, wr_data_space, rd_data_space
    );
endinterface

// File: rtl/sync_fifo_wc.sv
// Single-clock width-converting FIFO (STD: 1-cycle read latency, FWFT: head prefetched); writes drop with overflow when full.
// Define SYNC_FIFO_PARITY_EN to store even parity per narrow unit and flag mismatches on parity_err.
module sync_fifo_wc #(
    parameter int    INPUT_WIDTH  = 32,
    parameter int    OUTPUT_WIDTH = 8,
    parameter int    WR_DEPTH     = 16,
    parameter string MODE         = "FWFT",
    parameter string DIRECTION    = "LSB"
) (
    input logic           clock,
    input logic           reset_n,
    sync_fifo_wc_if.slave bus
);
    localparam int NW       = (INPUT_WIDTH < OUTPUT_WIDTH) ? INPUT_WIDTH : OUTPUT_WIDTH;
    localparam int R_IN     = INPUT_WIDTH / NW;
    localparam int R_OUT    = OUTPUT_WIDTH / NW;
    localparam int UNITS    = WR_DEPTH * R_IN;
    localparam int RD_DEPTH = UNITS / R_OUT;
    localparam int AW       = $clog2(UNITS);
    localparam int PW       = AW + 1;
    localparam int LOG_RI   = $clog2(R_IN);
    localparam int LOG_RO   = $clog2(R_OUT);
    localparam int WCW      = $clog2(WR_DEPTH) + 1;
    localparam int RCW      = $clog2(RD_DEPTH) + 1;
    localparam bit IS_FWFT  = (MODE == "FWFT");
    localparam bit IS_MSB   = (DIRECTION == "MSB");

    logic [NW-1:0]           mem [UNITS];
    logic [PW-1:0]           wr_ptr, rd_ptr, cnt_u, space_u;
    logic [AW-1:0]           wr_addr, rd_addr;
    logic [WCW-1:0]          wr_cnt;
    logic [RCW-1:0]          rd_cnt;
    logic                    full_c, empty_c, do_wr, do_rd;
    logic                    valid_q, valid_n, load_head, load_next, ovf_q, udf_q;
    logic [OUTPUT_WIDTH-1:0] dout_q, head_w, next_w;

    // Occupancy is kept in narrow units; whole-word counts are the floor of that.
    assign cnt_u   = wr_ptr - rd_ptr;
    assign space_u = PW'(UNITS) - cnt_u;
    assign wr_cnt  = cnt_u[PW-1:LOG_RI];
    assign rd_cnt  = cnt_u[PW-1:LOG_RO];
    assign full_c  = (space_u < PW'(R_IN));
    assign empty_c = (rd_cnt == '0);
    assign wr_addr = wr_ptr[AW-1:0];
    assign rd_addr = rd_ptr[AW-1:0];
    assign do_wr   = bus.wr_en & ~full_c & ~bus.flush;
    assign do_rd   = bus.rd_en & ~bus.flush & (IS_FWFT ? valid_q : ~empty_c);

    always_ff @(posedge clock) begin
        if (do_wr) begin
            for (int k = 0; k < R_IN; k++) begin
                mem[wr_addr + AW'(k)] <= bus.din[(IS_MSB ? R_IN-1-k : k)*NW +: NW];
            end
        end
    end

    // next_w is the word behind the head, so an FWFT pop can present it at the same edge.
    always_comb begin
        head_w = '0;
        next_w = '0;
        for (int k = 0; k < R_OUT; k++) begin
            head_w[(IS_MSB ? R_OUT-1-k : k)*NW +: NW] = mem[rd_addr + AW'(k)];
            next_w[(IS_MSB ? R_OUT-1-k : k)*NW +: NW] = mem[rd_addr + AW'(R_OUT + k)];
        end
    end

    // FWFT keeps the head in storage until popped, so rd_data_count includes it.
    always_comb begin
        load_head = 1'b0;
        load_next = 1'b0;
        valid_n   = 1'b0;
        if (!bus.flush) begin
            if (IS_FWFT) begin
                load_next = do_rd && (rd_cnt >= RCW'(2));
                load_head = !valid_q && !empty_c;
                valid_n   = load_next || load_head || (valid_q && !do_rd);
            end else begin
                load_head = do_rd;
                valid_n   = do_rd;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            valid_q <= 1'b0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            ovf_q   <= bus.wr_en & full_c & ~bus.flush;
            udf_q   <= bus.rd_en & ~bus.flush & (IS_FWFT ? ~valid_q : empty_c);
            valid_q <= valid_n;
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_wr) wr_ptr <= wr_ptr + PW'(R_IN);
                if (do_rd) rd_ptr <= rd_ptr + PW'(R_OUT);
            end
            if (load_next)      dout_q <= next_w;
            else if (load_head) dout_q <= head_w;
        end
    end

`ifdef SYNC_FIFO_PARITY_EN
    logic par_mem [UNITS];
    logic head_perr, next_perr, perr_q;

    always_ff @(posedge clock) begin
        if (do_wr) begin
            for (int k = 0; k < R_IN; k++) begin
                par_mem[wr_addr + AW'(k)] <= ^bus.din[(IS_MSB ? R_IN-1-k : k)*NW +: NW];
            end
        end
    end

    always_comb begin
        head_perr = 1'b0;
        next_perr = 1'b0;
        for (int k = 0; k < R_OUT; k++) begin
            head_perr |= par_mem[rd_addr + AW'(k)] ^ (^mem[rd_addr + AW'(k)]);
            next_perr |= par_mem[rd_addr + AW'(R_OUT + k)] ^ (^mem[rd_addr + AW'(R_OUT + k)]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) perr_q <= 1'b0;
        else          perr_q <= load_next ? next_perr : (load_head ? head_perr : 1'b0);
    end

    assign bus.parity_err = perr_q;
`endif

    assign bus.valid         = valid_q;
    assign bus.dout          = dout_q;
    assign bus.full          = full_c;
    assign bus.empty         = empty_c;
    assign bus.almost_full   = (wr_cnt >= bus.af_thresh);
    assign bus.almost_empty  = (rd_cnt <= bus.ae_thresh);
    assign bus.overflow      = ovf_q;
    assign bus.underflow     = udf_q;
    assign bus.wr_data_count = wr_cnt;
    assign bus.rd_data_count = rd_cnt;
    assign bus.wr_data_space = WCW'(WR_DEPTH) - wr_cnt;
    assign bus.rd_data_space = RCW'(RD_DEPTH) - rd_cnt;
endmodule
